// File: rtl/cos_series_eval_pkg.sv
// Shared fixed-point constants, FSM state type and accumulator saturation.
package cos_series_pkg;

  localparam int FRAC_BITS      = 14;
  localparam int COEF_FRAC_BITS = 16;
  localparam int ACC_W          = 18;

  localparam logic [15:0] ONE_Q2_14 = 16'h4000;
  localparam logic [15:0] U16_MAX   = 16'hFFFF;
  localparam logic [15:0] SAT_POS   = 16'h7FFF;
  localparam logic [15:0] SAT_NEG   = 16'h8000;

  localparam logic signed [ACC_W-1:0] ACC_MAX = 18'sh07FFF;
  localparam logic signed [ACC_W-1:0] ACC_MIN = 18'sh38000;

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    TERM,
    DONE
  } state_e;

  // Clamp the wide accumulator into a signed 16-bit Q2.14 result.
  function automatic logic [15:0] sat_acc(input logic signed [ACC_W-1:0] a);
    logic [15:0] r;
    if (a > ACC_MAX) begin
      r = SAT_POS;
    end else if (a < ACC_MIN) begin
      r = SAT_NEG;
    end else begin
      r = a[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/cos_series_eval_if.sv
// Angle/result handshakes plus the external coefficient table port.
interface cos_series_eval_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [ADDR_W-1:0] coef_addr;
  logic [DATA_W-1:0] coef_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_cos;

  // Evaluator side.
  modport slave (
    input  in_valid, in_x, coef_data, out_ready,
    output in_ready, coef_addr, out_valid, out_cos
  );

  // Angle source, coefficient table and result sink side.
  modport master (
    output in_valid, in_x, coef_data, out_ready,
    input  in_ready, coef_addr, out_valid, out_cos
  );

endinterface

// File: rtl/cos_series_eval_fx_mul_sat.sv
// Unsigned DATA_W x DATA_W multiply, right shift by SHIFT, saturate to DATA_W.
module fx_mul_sat
  import cos_series_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SHIFT  = 14
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] p_o
);

  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] shifted;

  assign prod    = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
  assign shifted = prod >> SHIFT;

  // Any bit above the result width means the value does not fit: clamp.
  always_comb begin
    p_o = shifted[DATA_W-1:0];
    if (shifted[2*DATA_W-1:DATA_W] != '0) begin
      p_o = U16_MAX[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/cos_series_eval.sv
// Sequential Maclaurin cosine: cos x = 1 - x^2/2! + x^4/4! - ...
// One series term per cycle, coefficients read from an external table.
module cos_series_eval
  import cos_series_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cos_series_eval_if.slave bus_if
);

  state_e                   state_q, state_d;
  logic [DATA_W-1:0]        x_q, x_d;
  logic [DATA_W-1:0]        xsq_q, xsq_d;
  logic [DATA_W-1:0]        pow_q, pow_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0]        k_q, k_d;

  logic [DATA_W-1:0]        x_abs;
  logic [DATA_W-1:0]        sq_w;
  logic [DATA_W-1:0]        pow_next_w;
  logic [DATA_W-1:0]        term_w;
  logic signed [ACC_W-1:0]  term_s;
  logic                     last_term;

  logic                     in_ready_w;
  logic                     out_valid_w;
  logic [DATA_W-1:0]        out_cos_w;
  logic [ADDR_W-1:0]        coef_addr_w;

  // x^2 is sign-independent, so square the magnitude through the unsigned
  // multiplier; 0x8000 stays 0x8000 (2.0) and its square saturates.
  assign x_abs = x_q[DATA_W-1] ? (~x_q + DATA_W'(1)) : x_q;

  fx_mul_sat #(.DATA_W(DATA_W), .SHIFT(FRAC_BITS)) u_square (
    .a_i (x_abs),
    .b_i (x_abs),
    .p_o (sq_w)
  );

  fx_mul_sat #(.DATA_W(DATA_W), .SHIFT(FRAC_BITS)) u_power (
    .a_i (pow_q),
    .b_i (xsq_q),
    .p_o (pow_next_w)
  );

  fx_mul_sat #(.DATA_W(DATA_W), .SHIFT(COEF_FRAC_BITS)) u_term (
    .a_i (pow_q),
    .b_i (bus_if.coef_data),
    .p_o (term_w)
  );

  assign term_s    = $signed({{(ACC_W-DATA_W){1'b0}}, term_w});
  assign last_term = (k_q == ADDR_W'(N_TERMS - 1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      xsq_q   <= '0;
      pow_q   <= '0;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      xsq_q   <= xsq_d;
      pow_q   <= pow_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
    end
  end

  // Next-state, datapath updates and handshake outputs decoded from state.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    xsq_d       = xsq_q;
    pow_d       = pow_q;
    acc_d       = acc_q;
    k_d         = k_q;
    in_ready_w  = 1'b0;
    out_valid_w = 1'b0;
    out_cos_w   = '0;
    coef_addr_w = '0;

    unique case (state_q)
      IDLE: begin
        in_ready_w = 1'b1;
        if (bus_if.in_valid) begin
          x_d     = bus_if.in_x;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        xsq_d   = sq_w;
        pow_d   = sq_w;
        acc_d   = ACC_W'(ONE_Q2_14);
        k_d     = '0;
        state_d = TERM;
      end
      TERM: begin
        coef_addr_w = k_q;
        // Even k subtracts (x^2/2!, x^6/6!, ...), odd k adds.
        if (k_q[0]) begin
          acc_d = acc_q + term_s;
        end else begin
          acc_d = acc_q - term_s;
        end
        pow_d = pow_next_w;
        k_d   = k_q + ADDR_W'(1);
        if (last_term) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_w = 1'b1;
        out_cos_w   = sat_acc(acc_q);
        if (bus_if.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus_if.in_ready  = in_ready_w;
  assign bus_if.out_valid = out_valid_w;
  assign bus_if.out_cos   = out_cos_w;
  assign bus_if.coef_addr = coef_addr_w;

endmodule

// File: tb/tb_cos_series_eval.sv
// Directed bench for cos_series_eval with a 1/(2k+2)! coefficient table.
module tb_cos_series_eval;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  cos_series_eval_if #(.ADDR_W(3), .DATA_W(16)) bus ();

  cos_series_eval #(.N_TERMS(4), .ADDR_W(3), .DATA_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Q0.16 coefficients 1/2!, 1/4!, 1/6!, 1/8!, 1/10! ... truncated.
  always_comb begin
    case (bus.coef_addr)
      3'd0:    bus.coef_data = 16'h8000;
      3'd1:    bus.coef_data = 16'h0AAA;
      3'd2:    bus.coef_data = 16'h005B;
      3'd3:    bus.coef_data = 16'h0001;
      default: bus.coef_data = 16'h0000;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = 16'h0000;
    bus.out_ready = 1'b0;
    #3;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    vectors++;
    if (bus.out_cos !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_out_cos got=%h exp=0000", bus.out_cos);
    end
    vectors++;
    if (bus.coef_addr !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_coef_addr got=%0d exp=0", bus.coef_addr);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_zero_angle();
    bus.in_x     = 16'h0000;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_busy_in_ready got=%b exp=0", bus.in_ready);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_early_valid cycle=%0d got=%b exp=0", i, bus.out_valid);
      end
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_latency_valid got=%b exp=1", bus.out_valid);
    end
    vectors++;
    if (bus.out_cos !== 16'h4000) begin
      miscompares++;
      $display("FAIL zero_out_cos got=%h exp=4000", bus.out_cos);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_release got valid=%b ready=%b exp valid=0 ready=1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_unit_angle();
    logic [2:0]         exp_addr [4];
    logic signed [17:0] exp_acc  [4];
    exp_addr = '{3'd0, 3'd1, 3'd2, 3'd3};
    exp_acc  = '{18'sh02000, 18'sh022AA, 18'sh02294, 18'sh02294};
    bus.in_x     = 16'h4000;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.coef_addr !== exp_addr[i]) begin
        miscompares++;
        $display("FAIL unit_coef_addr k=%0d got=%0d exp=%0d", i, bus.coef_addr, exp_addr[i]);
      end
      step();
      vectors++;
      if (dut.acc_q !== exp_acc[i]) begin
        miscompares++;
        $display("FAIL unit_acc k=%0d got=%h exp=%h", i, dut.acc_q, exp_acc[i]);
      end
    end
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_cos !== 16'h2294) begin
      miscompares++;
      $display("FAIL unit_out_cos got valid=%b cos=%h exp valid=1 cos=2294",
               bus.out_valid, bus.out_cos);
    end
    vectors++;
    if (bus.coef_addr !== 3'd0) begin
      miscompares++;
      $display("FAIL unit_done_coef_addr got=%0d exp=0", bus.coef_addr);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_symmetry();
    int cyc;
    bus.in_x     = 16'hC000;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    vectors++;
    if (cyc !== 5) begin
      miscompares++;
      $display("FAIL sym_latency got=%0d exp=5", cyc);
    end
    vectors++;
    if (bus.out_cos !== 16'h2294) begin
      miscompares++;
      $display("FAIL sym_out_cos got=%h exp=2294", bus.out_cos);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    bus.in_x     = 16'h4000;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    vectors++;
    if (cyc !== 5) begin
      miscompares++;
      $display("FAIL bp_latency got=%0d exp=5", cyc);
    end
    // A new angle is offered while the result is stalled.
    bus.in_x     = 16'h0000;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_cos !== 16'h2294 || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold cycle=%0d got valid=%b cos=%h ready=%b exp 1/2294/0",
                 i, bus.out_valid, bus.out_cos, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1",
               bus.out_valid, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    vectors++;
    if (cyc !== 5 || bus.out_cos !== 16'h4000) begin
      miscompares++;
      $display("FAIL bp_second got latency=%0d cos=%h exp latency=5 cos=4000", cyc, bus.out_cos);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bus.in_x     = 16'h4000;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    vectors++;
    if (bus.coef_addr !== 3'd2) begin
      miscompares++;
      $display("FAIL rst_mid_addr got=%0d exp=2", bus.coef_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.out_cos !== 16'h0000 || bus.coef_addr !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_mid_async got ready=%b valid=%b cos=%h addr=%0d exp 1/0/0000/0",
               bus.in_ready, bus.out_valid, bus.out_cos, bus.coef_addr);
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_held got valid=%b ready=%b exp valid=0 ready=1",
               bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b1;
    step();
    bus.in_x     = 16'h0000;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    vectors++;
    if (cyc !== 5 || bus.out_cos !== 16'h4000) begin
      miscompares++;
      $display("FAIL rst_mid_recover got latency=%0d cos=%h exp latency=5 cos=4000",
               cyc, bus.out_cos);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    int cyc;
    bus.in_x     = 16'h8000;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    vectors++;
    if (dut.xsq_q !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_xsq got=%h exp=ffff", dut.xsq_q);
    end
    // 1 - 7FFF + AA9 - 5A + 0 (x^2 clamped to FFFF) = -35B0
    vectors++;
    if (cyc !== 5 || bus.out_cos !== 16'hCA50) begin
      miscompares++;
      $display("FAIL sat_out_cos got latency=%0d cos=%h exp latency=5 cos=ca50",
               cyc, bus.out_cos);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_ready;
    logic exp_valid;
    bus.in_x      = 16'h4000;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_x = 16'h0000;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (i == 7) begin
        bus.in_valid = 1'b0;
      end
      exp_ready = (i == 6) || (i >= 13);
      exp_valid = (i == 5) || (i == 12);
      vectors++;
      if (bus.in_ready !== exp_ready || bus.out_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL b2b_hs cycle=%0d got ready=%b valid=%b exp ready=%b valid=%b",
                 i, bus.in_ready, bus.out_valid, exp_ready, exp_valid);
      end
      if (i == 5) begin
        vectors++;
        if (bus.out_cos !== 16'h2294) begin
          miscompares++;
          $display("FAIL b2b_first got=%h exp=2294", bus.out_cos);
        end
      end
      if (i == 12) begin
        vectors++;
        if (bus.out_cos !== 16'h4000) begin
          miscompares++;
          $display("FAIL b2b_second got=%h exp=4000", bus.out_cos);
        end
      end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_zero_angle();
    test_unit_angle();
    test_symmetry();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
